// File: rtl/circ_mtx_t_vec_mul_seq.sv
// Streaming transpose-circulant matrix-vector multiply over GF(2^W-1): r = C^T * v.
// One vector element per beat; N modular MACs update every output in parallel.
module circ_mtx_t_vec_mul_seq #(
  parameter int WORD_WIDTH = 31,
  parameter int MTX_SIZE   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [WORD_WIDTH*MTX_SIZE-1:0] mtx_row,
  input  logic [WORD_WIDTH-1:0]          in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [WORD_WIDTH*MTX_SIZE-1:0] result,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int W  = WORD_WIDTH;
  localparam int N  = MTX_SIZE;
  localparam int IW = $clog2(N);

  localparam logic [W:0]    P     = {1'b0, {W{1'b1}}};
  localparam logic [IW:0]   N_EXT = (IW+1)'(N);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  // Inputs to both reductions are below 2p, so one conditional subtract suffices.
  function automatic logic [W-1:0] mod_red(input logic [W:0] s);
    return (s >= P) ? W'(s - P) : s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    return mod_red({1'b0, a} + {1'b0, b});
  endfunction

  // 2^W == 1 mod p, so the high half of the product folds straight onto the low half.
  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return mod_red({1'b0, prod[W-1:0]} + {1'b0, prod[2*W-1:W]});
  endfunction

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [W-1:0]  r_row [N];
  logic [W-1:0]  r_acc [N];

  logic [W-1:0]  w_next [N];
  logic          w_accept;
  logic          w_first;
  logic [IW:0]   w_idx_ext;

  assign w_accept  = in_valid & r_in_ready;
  assign w_first   = (r_state == S_IDLE);
  assign w_idx_ext = {1'b0, r_idx};

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;

  for (genvar gi = 0; gi < N; gi++) begin : g_mac
    localparam logic [IW:0] I_EXT = (IW+1)'(gi);

    logic [IW-1:0] w_rot;
    logic [W-1:0]  w_coef;
    logic [W-1:0]  w_prod;
    logic [W-1:0]  w_base;

    // Column j contributes c[(i-j) mod N] to output i; wrap by adding N rather than dividing.
    assign w_rot  = (I_EXT >= w_idx_ext) ? IW'(I_EXT - w_idx_ext)
                                         : IW'(I_EXT + N_EXT - w_idx_ext);
    // Beat 0 uses the live row (rotation 0) and starts from zero instead of the old accumulator.
    assign w_coef = w_first ? mtx_row[gi*W +: W] : r_row[w_rot];
    assign w_base = w_first ? '0 : r_acc[gi];
    assign w_prod = mod_mul(w_coef, in_data);

    assign w_next[gi]         = mod_add(w_base, w_prod);
    assign result[gi*W +: W]  = r_acc[gi];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      // NOTE: row and accumulator arrays are reset because a cleared result is part of the contract.
      for (int i = 0; i < N; i++) begin
        r_row[i] <= '0;
        r_acc[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            for (int i = 0; i < N; i++) begin
              r_row[i] <= mtx_row[i*W +: W];
              r_acc[i] <= w_next[i];
            end
            r_idx   <= IW'(1);
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            for (int i = 0; i < N; i++) begin
              r_acc[i] <= w_next[i];
            end
            if (r_idx == LAST) begin
              r_idx       <= '0;
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circ_mtx_t_vec_mul_seq.sv
// Directed bench for circ_mtx_t_vec_mul_seq: N=4 instance for corner cases,
// N=16 instance for a back-to-back random run against a plain mod-p model.
module tb_circ_mtx_t_vec_mul_seq;

  localparam int W = 31;
  localparam logic [W-1:0] P = 31'h7FFF_FFFF;

  typedef logic [W-1:0] word_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass   = 0;
  int n_checks = 0;

  logic [4*W-1:0]  row4  = '0;
  word_t           din4  = '0;
  logic            vin4  = 1'b0;
  logic            ordy4 = 1'b0;
  logic            rdy4;
  logic            vout4;
  logic [4*W-1:0]  res4;

  logic [16*W-1:0] row16  = '0;
  word_t           din16  = '0;
  logic            vin16  = 1'b0;
  logic            ordy16 = 1'b0;
  logic            rdy16;
  logic            vout16;
  logic [16*W-1:0] res16;

  circ_mtx_t_vec_mul_seq #(.WORD_WIDTH(W), .MTX_SIZE(4)) dut4 (
    .clk(clk), .reset(reset), .mtx_row(row4), .in_data(din4), .in_valid(vin4),
    .in_ready(rdy4), .result(res4), .out_valid(vout4), .out_ready(ordy4)
  );

  circ_mtx_t_vec_mul_seq #(.WORD_WIDTH(W), .MTX_SIZE(16)) dut16 (
    .clk(clk), .reset(reset), .mtx_row(row16), .in_data(din16), .in_valid(vin16),
    .in_ready(rdy16), .result(res16), .out_valid(vout16), .out_ready(ordy16)
  );

  function automatic logic [4*W-1:0] pk4(input word_t a0, input word_t a1,
                                         input word_t a2, input word_t a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [4*W-1:0] pack4(input word_t a[16]);
    logic [4*W-1:0] r;
    for (int i = 0; i < 4; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  function automatic logic [16*W-1:0] pack16(input word_t a[16]);
    logic [16*W-1:0] r;
    for (int i = 0; i < 16; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  // Reference: r[i] = sum_j c[(i-j) mod n] * v[j] mod p, using 64-bit % arithmetic.
  function automatic void model(input int n, input word_t c[16], input word_t v[16],
                                output word_t r[16]);
    for (int i = 0; i < 16; i++) begin
      longint unsigned acc;
      acc = 0;
      if (i < n) begin
        for (int j = 0; j < n; j++) begin
          int k;
          k   = (i - j + n) % n;
          acc = (acc + 64'(c[k]) * 64'(v[j])) % 64'(P);
        end
      end
      r[i] = word_t'(acc);
    end
  endfunction

  function automatic word_t rnd();
    return word_t'($urandom_range(0, 32'h7FFF_FFFE));
  endfunction

  // Presents one beat and returns one cycle after it is accepted (time = posedge + 1).
  task automatic send4(input word_t d, input logic [4*W-1:0] row);
    int cnt;
    cnt  = 0;
    row4 = row;
    din4 = d;
    vin4 = 1'b1;
    while (rdy4 !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_checks++;
    if (cnt >= 40) $display("FAIL send4_timeout: in_ready=%b, required 1", rdy4);
    else n_pass++;
    @(posedge clk); #1;
    vin4 = 1'b0;
  endtask

  task automatic send16(input word_t d, input logic [16*W-1:0] row);
    int cnt;
    cnt   = 0;
    row16 = row;
    din16 = d;
    vin16 = 1'b1;
    while (rdy16 !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_checks++;
    if (cnt >= 40) $display("FAIL send16_timeout: in_ready=%b, required 1", rdy16);
    else n_pass++;
    @(posedge clk); #1;
    vin16 = 1'b0;
  endtask

  task automatic drain4();
    ordy4 = 1'b1;
    @(posedge clk); #1;
    ordy4 = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (rdy4 !== 1'b0) $display("FAIL reset_in_ready: got %b, required 0", rdy4);
    else n_pass++;
    n_checks++;
    if (vout4 !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", vout4);
    else n_pass++;
    n_checks++;
    if (res4 !== '0) $display("FAIL reset_result: got %h, required 0", res4);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (rdy4 !== 1'b1) $display("FAIL idle_in_ready: got %b, required 1", rdy4);
    else n_pass++;
  endtask

  task automatic test_unit_vectors();
    logic [4*W-1:0] row;
    row = pk4(1, 2, 3, 4);
    send4(1, row); send4(0, row); send4(0, row);
    n_checks++;
    if (vout4 !== 1'b0) $display("FAIL early_valid: got %b after 3 beats, required 0", vout4);
    else n_pass++;
    send4(0, row);
    n_checks++;
    if (vout4 !== 1'b1) $display("FAIL latency_valid: got %b after 4th beat, required 1", vout4);
    else n_pass++;
    n_checks++;
    if (res4 !== pk4(1, 2, 3, 4)) $display("FAIL unit_e0: got %h, required %h", res4, pk4(1, 2, 3, 4));
    else n_pass++;
    drain4();
    n_checks++;
    if (vout4 !== 1'b0) $display("FAIL valid_drop: got %b, required 0", vout4);
    else n_pass++;

    send4(0, row); send4(1, row); send4(0, row); send4(0, row);
    n_checks++;
    if (res4 !== pk4(4, 1, 2, 3)) $display("FAIL unit_e1: got %h, required %h", res4, pk4(4, 1, 2, 3));
    else n_pass++;
    drain4();
  endtask

  task automatic test_reduction();
    logic [4*W-1:0] row;
    row = pk4(P - 1, 0, 0, 0);
    send4(P - 1, row); send4(0, row); send4(0, row); send4(2, row);
    n_checks++;
    if (res4 !== pk4(1, 0, 0, P - 2))
      $display("FAIL reduction: got %h, required %h", res4, pk4(1, 0, 0, P - 2));
    else n_pass++;
    drain4();
  endtask

  task automatic test_backpressure();
    logic [4*W-1:0] row;
    logic [4*W-1:0] exp;
    row = pk4(1, 1, 1, 1);
    exp = pk4(P - 4, P - 4, P - 4, P - 4);
    for (int j = 0; j < 4; j++) send4(P - 1, row);
    n_checks++;
    if (res4 !== exp) $display("FAIL chained_add: got %h, required %h", res4, exp);
    else n_pass++;
    vin4 = 1'b1;
    din4 = 5;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (res4 !== exp || vout4 !== 1'b1 || rdy4 !== 1'b0)
        $display("FAIL hold_cycle%0d: result=%h out_valid=%b in_ready=%b, required %h 1 0",
                 k, res4, vout4, rdy4, exp);
      else n_pass++;
    end
    vin4 = 1'b0;
    drain4();
    row = pk4(1, 2, 3, 4);
    send4(0, row); send4(0, row); send4(1, row); send4(0, row);
    n_checks++;
    if (res4 !== pk4(3, 4, 1, 2)) $display("FAIL after_hold: got %h, required %h", res4, pk4(3, 4, 1, 2));
    else n_pass++;
    drain4();
  endtask

  task automatic test_random_valid();
    word_t c[16], v[16], r[16], junk[16];
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 16; i++) begin
        c[i]    = (i < 4) ? rnd() : '0;
        v[i]    = (i < 4) ? rnd() : '0;
        junk[i] = rnd();
      end
      model(4, c, v, r);
      ordy4 = 1'b1;
      for (int j = 0; j < 4; j++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
        end
        if (j == 3) ordy4 = 1'b0;
        send4(v[j], (j == 0) ? pack4(c) : pack4(junk));
      end
      n_checks++;
      if (res4 !== pack4(r)) $display("FAIL random_valid%0d: got %h, required %h", t, res4, pack4(r));
      else n_pass++;
      drain4();
    end
  endtask

  task automatic test_reset_mid();
    word_t c[16], v[16], r[16];
    logic [4*W-1:0] row;
    row = pk4(1, 2, 3, 4);
    send4(7, row); send4(9, row); send4(11, row);
    reset = 1'b0;
    #1;
    n_checks++;
    if (res4 !== '0 || vout4 !== 1'b0 || rdy4 !== 1'b0)
      $display("FAIL reset_mid: result=%h out_valid=%b in_ready=%b, required 0 0 0", res4, vout4, rdy4);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      c[i] = (i < 4) ? rnd() : '0;
      v[i] = (i < 4) ? rnd() : '0;
    end
    model(4, c, v, r);
    for (int j = 0; j < 4; j++) send4(v[j], pack4(c));
    n_checks++;
    if (res4 !== pack4(r)) $display("FAIL after_reset: got %h, required %h", res4, pack4(r));
    else n_pass++;
    drain4();
  endtask

  task automatic test_back_to_back();
    word_t c[16], v[16], r[16];
    int start;
    int errs;
    errs   = 0;
    ordy16 = 1'b1;
    start  = cyc;
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < 16; i++) begin
        c[i] = rnd();
        v[i] = rnd();
      end
      if (k == 0) begin
        c[0] = P - 1;
        v[0] = P - 1;
      end
      model(16, c, v, r);
      for (int j = 0; j < 16; j++) send16(v[j], pack16(c));
      n_checks++;
      if (res16 !== pack16(r) || vout16 !== 1'b1) begin
        if (errs < 5) $display("FAIL b2b_vec%0d: out_valid=%b got %h, required %h",
                               k, vout16, res16, pack16(r));
        errs++;
      end else n_pass++;
    end
    n_checks++;
    if (cyc - start !== 1699) $display("FAIL b2b_cycles: got %0d, required 1699", cyc - start);
    else n_pass++;
    ordy16 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1 ms");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unit_vectors();
    test_reduction();
    test_backpressure();
    test_random_valid();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
